// File: rtl/pong_score_keeper_if.sv
// rtl/pong_score_keeper_if.sv - goal/start inputs and score/control outputs of the score keeper
interface pong_score_keeper_if;
  logic       start;
  logic       left_goal;
  logic       right_goal;
  logic [3:0] rightPlayerScore;
  logic [3:0] leftPlayerScore;
  logic       ball_hold;
  logic       serve_dir;
  logic       game_over;
  logic       winner;

  modport master (
    output start, left_goal, right_goal,
    input  rightPlayerScore, leftPlayerScore, ball_hold, serve_dir, game_over, winner
  );

  modport slave (
    input  start, left_goal, right_goal,
    output rightPlayerScore, leftPlayerScore, ball_hold, serve_dir, game_over, winner
  );
endinterface

// File: rtl/pong_score_keeper.sv
// rtl/pong_score_keeper.sv - pong match sequencer: goal edges to scores, serve hold and game over
module pong_score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input logic                clk,
  input logic                reset,
  pong_score_keeper_if.slave bus
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, GAME_OVER} state_e;

  state_e          state_q, state_d;
  logic [3:0]      left_score_q, left_score_d;
  logic [3:0]      right_score_q, right_score_d;
  logic            ball_hold_q, ball_hold_d;
  logic            serve_dir_q, serve_dir_d;
  logic            game_over_q, game_over_d;
  logic            winner_q, winner_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            left_goal_q, right_goal_q;

  logic            left_edge, right_edge;
  logic [3:0]      left_inc, right_inc;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

  assign left_edge  = bus.left_goal  & ~left_goal_q;
  assign right_edge = bus.right_goal & ~right_goal_q;
  assign left_inc   = sat_inc(left_score_q);
  assign right_inc  = sat_inc(right_score_q);

  always_comb begin
    state_d       = state_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    serve_dir_d   = serve_dir_q;
    winner_d      = winner_q;
    hold_cnt_d    = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          left_score_d  = 4'd0;
          right_score_d = 4'd0;
          state_d       = PLAY;
        end
      end
      PLAY: begin
        // A simultaneous double goal is ambiguous, so neither side scores.
        if (left_edge && !right_edge) begin
          right_score_d = right_inc;
          serve_dir_d   = 1'b0;
          if (right_inc == 4'(WIN_SCORE)) begin
            winner_d = 1'b1;
            state_d  = GAME_OVER;
          end else begin
            hold_cnt_d = CW'(HOLD_CYCLES - 1);
            state_d    = HOLD;
          end
        end else if (right_edge && !left_edge) begin
          left_score_d = left_inc;
          serve_dir_d  = 1'b1;
          if (left_inc == 4'(WIN_SCORE)) begin
            winner_d = 1'b0;
            state_d  = GAME_OVER;
          end else begin
            hold_cnt_d = CW'(HOLD_CYCLES - 1);
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = PLAY;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      GAME_OVER: begin
        if (bus.start) begin
          left_score_d  = 4'd0;
          right_score_d = 4'd0;
          winner_d      = 1'b0;
          serve_dir_d   = 1'b0;
          state_d       = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase

    // Controls are derived from the next state so they are registered alongside it.
    ball_hold_d = (state_d != PLAY);
    game_over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      left_score_q  <= 4'd0;
      right_score_q <= 4'd0;
      ball_hold_q   <= 1'b1;
      serve_dir_q   <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      hold_cnt_q    <= '0;
      left_goal_q   <= 1'b0;
      right_goal_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      ball_hold_q   <= ball_hold_d;
      serve_dir_q   <= serve_dir_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      hold_cnt_q    <= hold_cnt_d;
      left_goal_q   <= bus.left_goal;
      right_goal_q  <= bus.right_goal;
    end
  end

  assign bus.leftPlayerScore  = left_score_q;
  assign bus.rightPlayerScore = right_score_q;
  assign bus.ball_hold        = ball_hold_q;
  assign bus.serve_dir        = serve_dir_q;
  assign bus.game_over        = game_over_q;
  assign bus.winner           = winner_q;
endmodule

// File: tb/tb_pong_score_keeper.sv
// tb/tb_pong_score_keeper.sv - directed and randomized bench for pong_score_keeper against a match model
module tb_pong_score_keeper;
  localparam int WIN  = 7;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  pong_score_keeper_if bus ();

  pong_score_keeper #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Match model: mode 0 idle, 1 rally, 2 serve hold, 3 match decided.
  int m_mode, m_left, m_right, m_hold_left;
  bit m_dir, m_win, m_pl, m_pr;

  function automatic logic [11:0] exp_vec();
    return {4'(m_left), 4'(m_right), (m_mode != 1), m_dir, (m_mode == 3), m_win};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bus.leftPlayerScore, bus.rightPlayerScore, bus.ball_hold,
            bus.serve_dir, bus.game_over, bus.winner};
  endfunction

  task automatic model_edge(input bit rst, input bit st, input bit lg, input bit rg);
    bit le, re;
    le = lg && !m_pl;
    re = rg && !m_pr;
    if (rst) begin
      m_mode = 0; m_left = 0; m_right = 0; m_hold_left = 0;
      m_dir = 0; m_win = 0; m_pl = 0; m_pr = 0;
      return;
    end
    m_pl = lg;
    m_pr = rg;
    case (m_mode)
      0: if (st) begin m_left = 0; m_right = 0; m_mode = 1; end
      1: if (le != re) begin
           if (le) begin
             m_right = (m_right >= 9) ? 9 : m_right + 1;
             m_dir = 0;
             if (m_right == WIN) begin m_mode = 3; m_win = 1; end
             else begin m_mode = 2; m_hold_left = HOLD; end
           end else begin
             m_left = (m_left >= 9) ? 9 : m_left + 1;
             m_dir = 1;
             if (m_left == WIN) begin m_mode = 3; m_win = 0; end
             else begin m_mode = 2; m_hold_left = HOLD; end
           end
         end
      2: begin
           m_hold_left--;
           if (m_hold_left == 0) m_mode = 1;
         end
      default: if (st) begin m_left = 0; m_right = 0; m_win = 0; m_dir = 0; m_mode = 1; end
    endcase
  endtask

  task automatic drive(input bit rst, input bit st, input bit lg, input bit rg);
    @(negedge clk);
    reset = rst; bus.start = st; bus.left_goal = lg; bus.right_goal = rg;
    @(posedge clk);
    model_edge(rst, st, lg, rg);
    #1;
  endtask

  // Scores one point with a clean pulse and waits out the serve hold.
  task automatic point(input bit lg, input bit rg);
    int n;
    drive(0, 0, lg, rg);
    drive(0, 0, 0, 0);
    n = 0;
    while (bus.ball_hold && !bus.game_over && n < 40) begin
      drive(0, 0, 0, 0);
      n++;
    end
    vectors++;
    if (n >= 40 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL point: got %h want %h (wait %0d)", dut_vec(), exp_vec(), n);
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    vectors++;
    if (dut_vec() !== 12'b0000_0000_1000) begin
      miscompares++;
      $display("FAIL reset_values: got %h want %h", dut_vec(), 12'b0000_0000_1000);
    end
    drive(0, 0, 0, 0);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL idle_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_goal_held();
    int holds, n;
    drive(0, 1, 0, 0);
    holds = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0);
      if (bus.ball_hold) holds++;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL goal_held_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n = 0;
    while (bus.ball_hold && n < 30) begin
      drive(0, 0, 0, 0);
      if (bus.ball_hold) holds++;
      n++;
    end
    vectors++;
    if (holds !== HOLD) begin
      miscompares++;
      $display("FAIL goal_held_hold_len: got %0d want %0d", holds, HOLD);
    end
    vectors++;
    if ({bus.rightPlayerScore, bus.leftPlayerScore, bus.serve_dir, bus.ball_hold} !== 10'b0001_0000_0_0) begin
      miscompares++;
      $display("FAIL goal_held_scores: got r%0d l%0d dir%b hold%b want r1 l0 dir0 hold0",
               bus.rightPlayerScore, bus.leftPlayerScore, bus.serve_dir, bus.ball_hold);
    end
  endtask

  task automatic test_simultaneous();
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    vectors++;
    if ({bus.rightPlayerScore, bus.leftPlayerScore, bus.ball_hold} !== 9'b0001_0000_0) begin
      miscompares++;
      $display("FAIL simultaneous: got r%0d l%0d hold%b want r1 l0 hold0",
               bus.rightPlayerScore, bus.leftPlayerScore, bus.ball_hold);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_win();
    for (int i = 0; i < WIN; i++) point(0, 1);
    vectors++;
    if ({bus.leftPlayerScore, bus.game_over, bus.winner, bus.ball_hold} !== 7'b0111_1_0_1) begin
      miscompares++;
      $display("FAIL win_state: got l%0d over%b win%b hold%b want l7 over1 win0 hold1",
               bus.leftPlayerScore, bus.game_over, bus.winner, bus.ball_hold);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
    end
    vectors++;
    if (bus.leftPlayerScore !== 4'd7 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL win_frozen: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_restart();
    drive(0, 1, 0, 0);
    vectors++;
    if (dut_vec() !== 12'b0000_0000_0000) begin
      miscompares++;
      $display("FAIL restart: got %h want %h", dut_vec(), 12'b0000_0000_0000);
    end
  endtask

  task automatic test_hold_ignore();
    int holds, n;
    drive(0, 0, 1, 0);
    holds = 1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0);
      if (bus.ball_hold) holds++;
    end
    drive(0, 1, 0, 1);
    if (bus.ball_hold) holds++;
    n = 0;
    while (bus.ball_hold && n < 30) begin
      drive(0, 0, 0, 0);
      if (bus.ball_hold) holds++;
      n++;
    end
    vectors++;
    if (holds !== HOLD) begin
      miscompares++;
      $display("FAIL hold_ignore_len: got %0d want %0d", holds, HOLD);
    end
    vectors++;
    if ({bus.rightPlayerScore, bus.leftPlayerScore} !== 8'h10 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL hold_ignore_scores: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    point(1, 0);
    for (int i = 0; i < 3; i++) point(0, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    vectors++;
    if ({bus.leftPlayerScore, bus.rightPlayerScore, bus.ball_hold} !== 9'b0100_0010_1) begin
      miscompares++;
      $display("FAIL reset_mid_setup: got l%0d r%0d hold%b want l4 r2 hold1",
               bus.leftPlayerScore, bus.rightPlayerScore, bus.ball_hold);
    end
    drive(1, 0, 0, 0);
    vectors++;
    if (dut_vec() !== 12'b0000_0000_1000) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want %h", dut_vec(), 12'b0000_0000_1000);
    end
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    vectors++;
    if (dut_vec() !== 12'b0000_0000_1000 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL idle_goal_ignored: got %h want %h", dut_vec(), 12'b0000_0000_1000);
    end
  endtask

  task automatic test_random();
    bit lg, rg, st, rst;
    lg = 0; rg = 0;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) lg = ~lg;
      if ($urandom_range(0, 5) == 0) rg = ~rg;
      drive(rst, st, lg, rg);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.left_goal = 1'b0;
    bus.right_goal = 1'b0;
    test_reset();
    test_goal_held();
    test_simultaneous();
    test_win();
    test_restart();
    test_hold_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
- Upstream stage of the seven-segment score display in the pong design; produces the `rightPlayerScore` and `leftPlayerScore` nibbles it consumes.
- Converts goal events from the ball/collision logic into per-player point counts.
- Sequences the match: idle, play, post-point ball hold, game over.
- Drives the ball-hold and game-over controls back to the game logic.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..9, so every score stays a single decimal digit.
HOLD_CYCLES, 100_000_000, clk cycles the ball is held after a point (1 s at 100 MHz); legal minimum 1; benches override small, e.g. 8.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
start  input  1  debounced single-cycle pulse from the start/new-game button
left_goal  input  1  level, high while the ball is past the left wall; scores for the right player
right_goal  input  1  level, high while the ball is past the right wall; scores for the left player
rightPlayerScore  output  4  right player points, binary 0..9
leftPlayerScore  output  4  left player points, binary 0..9
ball_hold  output  1  high means the ball logic must recentre and freeze the ball
serve_dir  output  1  direction of the next serve: 0 = toward the left player, 1 = toward the right player
game_over  output  1  high while in GAME_OVER
winner  output  1  valid when game_over is high: 0 = left player won, 1 = right player won

Behaviour:
- All state is registered on the rising edge of clk. No combinational path exists from inputs to outputs.
- Reset values:
  - state = IDLE
  - both scores = 0
  - ball_hold = 1, serve_dir = 0, game_over = 0, winner = 0
  - hold counter = 0, goal edge registers = 0
- Goal detection:
  - Each goal input is edge-detected against a registered copy from the previous cycle.
  - Only a 0->1 transition counts; a level held for many cycles scores exactly once.
  - The edge registers update every cycle in every state, so a goal level that is already high when PLAY is entered does not score.
- States:
  - IDLE: ball_hold = 1. On start, clear both scores and go to PLAY. Goal edges are ignored.
  - PLAY: ball_hold = 0. A goal edge from exactly one input is handled as follows:
    - The scoring player's score increments, visible one cycle after the edge is sampled.
    - serve_dir is set toward the player who conceded: left_goal -> 0, right_goal -> 1.
    - If the new score equals WIN_SCORE, go to GAME_OVER and set winner. Otherwise load the hold counter with HOLD_CYCLES-1 and go to HOLD.
    - Both goal edges in the same cycle: both are ignored, there is no score change, and the block stays in PLAY.
    - start is ignored in PLAY.
  - HOLD: ball_hold = 1. The counter decrements each cycle. Goal edges and start are ignored. Leave for PLAY in the cycle after the counter reads 0, which gives exactly HOLD_CYCLES cycles of ball_hold = 1.
  - GAME_OVER: ball_hold = 1, game_over = 1. Scores and winner are frozen. On start:
    - clear both scores, game_over and winner
    - reset serve_dir to 0
    - go directly to PLAY
- Arithmetic:
  - Scores increment as 4-bit binary and saturate at 9 (defensive; unreachable with a legal WIN_SCORE).
  - The hold counter is $clog2(HOLD_CYCLES+1) bits wide.
- Reset mid-operation: reset has priority over every other input in every state. The block returns to reset values on the next edge, including from HOLD with the counter partially elapsed.
- Output encoding: the scores are plain binary, which equals BCD for 0..9. The display consumes them unchanged.

Test Plan:
- Reset, then start, then left_goal held high for 5 cycles -> rightPlayerScore = 1 (exactly once), leftPlayerScore = 0, serve_dir = 0, ball_hold = 1 for exactly HOLD_CYCLES (8) cycles, then 0 in PLAY.
- From PLAY, left_goal and right_goal rise in the same cycle -> both scores unchanged, state remains PLAY, ball_hold stays 0.
- Seven right_goal edges separated by completed holds (WIN_SCORE = 7) -> leftPlayerScore = 7, game_over = 1, winner = 0, ball_hold = 1; further goal edges leave leftPlayerScore at 7.
- In GAME_OVER, pulse start -> next cycle both scores = 0, game_over = 0, serve_dir = 0, ball_hold = 0 (PLAY).
- Pulse start and right_goal during HOLD at counter = 3 -> no score change, and HOLD ends on schedule.
- Assert reset for 1 cycle during HOLD with scores 4/2 -> both scores 0 and ball_hold = 1; a subsequent left_goal edge without start does not score (IDLE).
